// File: rtl/track_scanline_renderer.sv
// Per-scanline road renderer for the VGA pipeline.
// During horizontal blank it fetches a track descriptor for the next line
// and turns it into saturated section edges and lane divider positions.
// In the visible part of the line it walks the sections left to right and
// drives one registered 12-bit colour per pixel.
module track_scanline_renderer #(
   parameter int          H_ACTIVE   = 640,
   parameter int          H_TOTAL    = 800,
   parameter int          V_ACTIVE   = 480,
   parameter int          HORIZON    = 240,
   parameter int          XW         = 10,
   parameter int          LANES      = 2,
   parameter int          MARK_W     = 4,
   parameter logic [11:0] SKY_RGB    = 12'h00F,
   parameter logic [11:0] GRASS_RGB  = 12'h0F0,
   parameter logic [11:0] ROAD_RGB   = 12'h333,
   parameter logic [11:0] MARK_RGB   = 12'hFFF,
   parameter logic [11:0] KERB_A_RGB = 12'hFFF,
   parameter logic [11:0] KERB_B_RGB = 12'hF00
) (
   input  logic          pixel_clk,
   input  logic          reset_n,
   input  logic [XW-1:0] DrawX,
   input  logic [XW-1:0] DrawY,
   output logic          desc_req,
   output logic [XW-1:0] desc_line,
   input  logic          desc_valid,
   input  logic [XW-1:0] desc_center,
   input  logic [XW-1:0] desc_half,
   input  logic [XW-1:0] desc_kerb,
   input  logic          desc_stripe,
   output logic          desc_miss,
   output logic [3:0]    red,
   output logic [3:0]    green,
   output logic [3:0]    blue
);

   localparam int XW1        = XW + 1;
   localparam int LOG2_LANES = $clog2(LANES);

   // Column / line landmarks at the working width.
   localparam logic [XW-1:0] ZERO_X     = XW'(0);
   localparam logic [XW-1:0] ONE_X      = XW'(1);
   localparam logic [XW-1:0] X_ACT      = XW'(H_ACTIVE);
   localparam logic [XW-1:0] X_DEADLINE = XW'(H_TOTAL - 4);
   localparam logic [XW-1:0] Y_REQ_LO   = XW'(HORIZON - 1);
   localparam logic [XW-1:0] Y_REQ_HI   = XW'(V_ACTIVE - 1);
   localparam logic [XW-1:0] Y_HORIZON  = XW'(HORIZON);
   localparam logic [XW-1:0] Y_ACT      = XW'(V_ACTIVE);
   localparam logic [XW:0]   X_ACT_W    = XW1'(H_ACTIVE);
   localparam logic [XW:0]   MARK_W_W   = XW1'(MARK_W);

   typedef enum logic [2:0] {
      ST_SKY     = 3'd0,
      ST_GRASS_L = 3'd1,
      ST_KERB_L  = 3'd2,
      ST_ROAD    = 3'd3,
      ST_KERB_R  = 3'd4,
      ST_GRASS_R = 3'd5,
      ST_BLANK   = 3'd6
   } section_t;

   // Handshake state and latched descriptor.
   logic          desc_req_r;
   logic [XW-1:0] desc_line_r;
   logic          desc_miss_r;
   logic          edge_upd_r;
   logic [XW-1:0] center_r;
   logic [XW-1:0] half_r;
   logic [XW-1:0] kerb_w_r;
   logic          stripe_r;
   logic          accept_s;
   logic          deadline_s;

   // Edge geometry used while drawing; only refreshed in blank.
   logic [XW-1:0] road_l_s, road_r_s, kerb_l_s, kerb_r_s, lane_w_s;
   logic [XW-1:0] lane_pos_s [LANES];
   logic [XW-1:0] road_l_r, road_r_r, kerb_l_r, kerb_r_r;
   logic [XW-1:0] lane_pos_r [LANES];
   logic          draw_stripe_r;

   // Renderer state.
   section_t      sec_r;
   section_t      sec_next_s;
   logic          in_mark_s;
   logic [11:0]   rgb_r;

   // Clamp a widened result into 0..H_ACTIVE.
   function automatic logic [XW-1:0] clamp_x(input logic [XW:0] v);
      return (v > X_ACT_W) ? X_ACT : v[XW-1:0];
   endfunction

   // Saturating a+b, ceiling H_ACTIVE.
   function automatic logic [XW-1:0] sat_add(input logic [XW-1:0] a, input logic [XW-1:0] b);
      logic [XW:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return clamp_x(sum);
   endfunction

   // Saturating a-b, floor 0 and ceiling H_ACTIVE.
   function automatic logic [XW-1:0] sat_sub(input logic [XW-1:0] a, input logic [XW-1:0] b);
      logic [XW:0] diff;
      diff = (b > a) ? {XW1{1'b0}} : {1'b0, a - b};
      return clamp_x(diff);
   endfunction

   // Walk the section chain for one column; zero-width sections fall
   // through in the same cycle because each test sees the updated state.
   function automatic section_t step_section(
      input section_t      cur,
      input logic [XW-1:0] x,
      input logic [XW-1:0] y,
      input logic [XW-1:0] kerb_l,
      input logic [XW-1:0] road_l,
      input logic [XW-1:0] road_r,
      input logic [XW-1:0] kerb_r
   );
      section_t s;
      s = cur;
      if (x == X_ACT) begin
         s = ST_BLANK;
      end else begin
         if (x == ZERO_X) begin
            s = ((y < Y_HORIZON) || (y >= Y_ACT)) ? ST_SKY : ST_GRASS_L;
         end else begin
            s = s;
         end
         if ((s == ST_GRASS_L) && (x >= kerb_l)) s = ST_KERB_L;
         else                                    s = s;
         if ((s == ST_KERB_L) && (x >= road_l))  s = ST_ROAD;
         else                                    s = s;
         if ((s == ST_ROAD) && (x >= road_r))    s = ST_KERB_R;
         else                                    s = s;
         if ((s == ST_KERB_R) && (x >= kerb_r))  s = ST_GRASS_R;
         else                                    s = s;
      end
      return s;
   endfunction

   // Colour lookup for a section.
   function automatic logic [11:0] section_rgb(input section_t s, input logic stripe, input logic mark);
      logic [11:0] c;
      case (s)
         ST_SKY:                 c = SKY_RGB;
         ST_GRASS_L, ST_GRASS_R: c = GRASS_RGB;
         ST_KERB_L, ST_KERB_R:   c = stripe ? KERB_A_RGB : KERB_B_RGB;
         ST_ROAD:                c = (stripe && mark) ? MARK_RGB : ROAD_RGB;
         ST_BLANK:               c = 12'h000;
         default:                c = 12'h000;
      endcase
      return c;
   endfunction

   // Acceptance is only legal before the deadline column; at and after it
   // an outstanding request times out instead, so the two never coincide.
   assign accept_s   = desc_req_r & desc_valid & (DrawX < X_DEADLINE);
   assign deadline_s = desc_req_r & (DrawX >= X_DEADLINE);

   // Descriptor request / accept / deadline handshake.
   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         desc_req_r  <= 1'b0;
         desc_line_r <= ZERO_X;
         desc_miss_r <= 1'b0;
         edge_upd_r  <= 1'b0;
         center_r    <= ZERO_X;
         half_r      <= ZERO_X;
         kerb_w_r    <= ZERO_X;
         stripe_r    <= 1'b0;
      end else begin
         desc_miss_r <= 1'b0;
         edge_upd_r  <= accept_s | deadline_s;
         if (accept_s) begin
            desc_req_r <= 1'b0;
            center_r   <= desc_center;
            half_r     <= desc_half;
            kerb_w_r   <= desc_kerb;
            stripe_r   <= desc_stripe;
         end else if (deadline_s) begin
            desc_req_r  <= 1'b0;
            desc_miss_r <= 1'b1;
         end else if ((DrawX == X_ACT) && (DrawY >= Y_REQ_LO) && (DrawY < Y_REQ_HI)) begin
            desc_req_r  <= 1'b1;
            desc_line_r <= DrawY + ONE_X;
         end
      end
   end

   // Saturated edge and divider arithmetic from the latched descriptor.
   always_comb begin
      road_l_s = sat_sub(center_r, half_r);
      road_r_s = sat_add(center_r, half_r);
      kerb_l_s = sat_sub(road_l_s, kerb_w_r);
      kerb_r_s = sat_add(road_r_s, kerb_w_r);
      lane_w_s = clamp_x({half_r, 1'b0} >> LOG2_LANES);
      lane_pos_s[0] = road_l_s;
      for (int i = 1; i < LANES; i++) begin
         lane_pos_s[i] = sat_add(lane_pos_s[i-1], lane_w_s);
      end
   end

   // Edge registers, refreshed one cycle after accept or deadline (in blank).
   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         road_l_r      <= ZERO_X;
         road_r_r      <= ZERO_X;
         kerb_l_r      <= ZERO_X;
         kerb_r_r      <= ZERO_X;
         draw_stripe_r <= 1'b0;
         for (int i = 0; i < LANES; i++) lane_pos_r[i] <= ZERO_X;
      end else if (edge_upd_r) begin
         road_l_r      <= road_l_s;
         road_r_r      <= road_r_s;
         kerb_l_r      <= kerb_l_s;
         kerb_r_r      <= kerb_r_s;
         draw_stripe_r <= stripe_r;
         for (int i = 0; i < LANES; i++) lane_pos_r[i] <= lane_pos_s[i];
      end
   end

   // Lane marker hit: position 0 is the left road edge, dividers are 1..LANES-1.
   always_comb begin
      in_mark_s = 1'b0;
      for (int k = 0; k < LANES; k++) begin
         in_mark_s = in_mark_s | ((k > 0) &&
                     ({1'b0, DrawX} >= {1'b0, lane_pos_r[k]}) &&
                     ({1'b0, DrawX} <  ({1'b0, lane_pos_r[k]} + MARK_W_W)));
      end
   end

   assign sec_next_s = step_section(sec_r, DrawX, DrawY, kerb_l_r, road_l_r, road_r_r, kerb_r_r);

   // Section FSM with registered colour output.
   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         sec_r <= ST_BLANK;
         rgb_r <= 12'h000;
      end else begin
         sec_r <= sec_next_s;
         rgb_r <= section_rgb(sec_next_s, draw_stripe_r, in_mark_s);
      end
   end

   assign desc_req  = desc_req_r;
   assign desc_line = desc_line_r;
   assign desc_miss = desc_miss_r;
   assign red       = rgb_r[11:8];
   assign green     = rgb_r[7:4];
   assign blue      = rgb_r[3:0];

endmodule

// File: tb/tb_track_scanline_renderer.sv
// Directed bench for track_scanline_renderer: drives whole scanlines,
// captures colour and handshake per column, then checks hand-computed spans.
module tb_track_scanline_renderer;

   localparam int XW = 10;
   localparam logic [11:0] SKY    = 12'h00F;
   localparam logic [11:0] GRASS  = 12'h0F0;
   localparam logic [11:0] ROAD   = 12'h333;
   localparam logic [11:0] MARK   = 12'hFFF;
   localparam logic [11:0] KERB_A = 12'hFFF;
   localparam logic [11:0] KERB_B = 12'hF00;
   localparam logic [11:0] BLACK  = 12'h000;
   localparam int NEVER = 9999;

   logic          pixel_clk;
   logic          reset_n;
   logic [XW-1:0] DrawX, DrawY;
   logic          desc_req;
   logic [XW-1:0] desc_line;
   logic          desc_valid;
   logic [XW-1:0] desc_center, desc_half, desc_kerb;
   logic          desc_stripe;
   logic          desc_miss;
   logic [3:0]    red, green, blue;

   int n_vectors     = 0;
   int n_miscompares = 0;

   logic [11:0]   cap_rgb  [0:799];
   logic          cap_req  [0:799];
   logic          cap_miss [0:799];
   logic [XW-1:0] cap_line [0:799];

   track_scanline_renderer dut (
      .pixel_clk  (pixel_clk),
      .reset_n    (reset_n),
      .DrawX      (DrawX),
      .DrawY      (DrawY),
      .desc_req   (desc_req),
      .desc_line  (desc_line),
      .desc_valid (desc_valid),
      .desc_center(desc_center),
      .desc_half  (desc_half),
      .desc_kerb  (desc_kerb),
      .desc_stripe(desc_stripe),
      .desc_miss  (desc_miss),
      .red        (red),
      .green      (green),
      .blue       (blue)
   );

   initial pixel_clk = 1'b0;
   always #5 pixel_clk = ~pixel_clk;

   task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_vectors++;
      if (observed !== expected) begin
         n_miscompares++;
         $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // One comparison per span: reports the first offending column, if any.
   task automatic check_span(input string tag, input int lo, input int hi, input logic [11:0] exp_rgb);
      int bad;
      bad = lo;
      for (int x = hi; x >= lo; x--) begin
         if (cap_rgb[x] !== exp_rgb) bad = x;
      end
      check_value($sformatf("%s@x%0d", tag, bad), {20'h0, cap_rgb[bad]}, {20'h0, exp_rgb});
   endtask

   function automatic int count_miss();
      int n;
      n = 0;
      for (int x = 0; x < 800; x++) n += int'(cap_miss[x]);
      return n;
   endfunction

   function automatic int count_req();
      int n;
      n = 0;
      for (int x = 0; x < 800; x++) n += int'(cap_req[x]);
      return n;
   endfunction

   task automatic set_desc(input int c, input int h, input int k, input logic s);
      desc_center = XW'(c);
      desc_half   = XW'(h);
      desc_kerb   = XW'(k);
      desc_stripe = s;
   endtask

   // Drive columns 0..x_end-1 of line y; desc_valid high for v_from..v_to.
   task automatic run_line(input int y, input int x_end, input int v_from, input int v_to);
      for (int x = 0; x < x_end; x++) begin
         DrawX      = XW'(x);
         DrawY      = XW'(y);
         desc_valid = (x >= v_from) && (x <= v_to);
         @(posedge pixel_clk);
         #1;
         cap_rgb[x]  = {red, green, blue};
         cap_req[x]  = desc_req;
         cap_miss[x] = desc_miss;
         cap_line[x] = desc_line;
      end
      desc_valid = 1'b0;
   endtask

   task automatic check_nominal(input string pfx, input logic [11:0] kerb, input logic [11:0] mark);
      check_span({pfx, "_grass_l"}, 0,   209, GRASS);
      check_span({pfx, "_kerb_l"},  210, 219, kerb);
      check_span({pfx, "_road_l"},  220, 319, ROAD);
      check_span({pfx, "_mark"},    320, 323, mark);
      check_span({pfx, "_road_r"},  324, 419, ROAD);
      check_span({pfx, "_kerb_r"},  420, 429, kerb);
      check_span({pfx, "_grass_r"}, 430, 639, GRASS);
      check_span({pfx, "_blank"},   640, 799, BLACK);
   endtask

   task automatic check_saturated(input string pfx);
      check_span({pfx, "_x0_road"}, 0,  0,   ROAD);
      check_span({pfx, "_road"},    0,  69,  ROAD);
      check_span({pfx, "_kerb_r"},  70, 79,  KERB_B);
      check_span({pfx, "_grass_r"}, 80, 639, GRASS);
   endtask

   initial begin
      reset_n    = 1'b0;
      DrawX      = '0;
      DrawY      = '0;
      desc_valid = 1'b0;
      set_desc(0, 0, 0, 1'b0);
      repeat (3) @(posedge pixel_clk);
      #1;
      check_value("rst_rgb",  {20'h0, red, green, blue}, 32'h0);
      check_value("rst_req",  {31'h0, desc_req},  32'h0);
      check_value("rst_miss", {31'h0, desc_miss}, 32'h0);
      check_value("rst_line", {22'h0, desc_line}, 32'h0);
      reset_n = 1'b1;

      // Line 239: all sky, requests line 240, never served -> miss.
      run_line(239, 800, NEVER, NEVER);
      check_span("sky", 0, 639, SKY);
      check_span("sky_blank", 640, 799, BLACK);
      check_value("req_pre_239",   {31'h0, cap_req[639]}, 32'h0);
      check_value("req_rise_239",  {31'h0, cap_req[640]}, 32'h1);
      check_value("req_line_240",  {22'h0, cap_line[640]}, 32'd240);
      check_value("req_hold_795",  {31'h0, cap_req[795]}, 32'h1);
      check_value("miss_pre_dl",   {31'h0, cap_miss[795]}, 32'h0);
      check_value("miss_at_dl",    {31'h0, cap_miss[796]}, 32'h1);
      check_value("req_drop_dl",   {31'h0, cap_req[796]}, 32'h0);
      check_value("miss_count_239", count_miss(), 32'd1);

      // Line 240: first track line after reset is all grass; nominal
      // descriptor offered on the first request cycle.
      set_desc(320, 100, 10, 1'b1);
      run_line(240, 800, 641, 641);
      check_span("grass_after_rst", 0, 639, GRASS);
      check_value("req_line_241",    {22'h0, cap_line[641]}, 32'd241);
      check_value("req_drop_accept", {31'h0, cap_req[641]}, 32'h0);
      check_value("miss_count_240",  count_miss(), 32'd0);

      // Line 300: nominal geometry, stripe=1.
      set_desc(320, 100, 10, 1'b0);
      run_line(300, 800, 641, 799);
      check_nominal("nom", KERB_A, MARK);
      check_value("req_line_301", {22'h0, cap_line[641]}, 32'd301);

      // Line 301: same geometry, stripe=0 -> red kerbs, no marker.
      set_desc(20, 50, 10, 1'b0);
      run_line(301, 800, 700, 700);
      check_nominal("nostripe", KERB_B, ROAD);
      check_value("req_hold_699", {31'h0, cap_req[699]}, 32'h1);
      check_value("req_drop_700", {31'h0, cap_req[700]}, 32'h0);

      // Line 302: saturated geometry; valid only from the deadline on -> ignored.
      set_desc(320, 100, 10, 1'b1);
      run_line(302, 800, 796, 799);
      check_saturated("sat");
      check_value("miss_302_at_dl", {31'h0, cap_miss[796]}, 32'h1);
      check_value("miss_count_302", count_miss(), 32'd1);

      // Line 303: previous geometry repeats; valid at H_TOTAL-5 is accepted.
      run_line(303, 800, 795, 795);
      check_saturated("sat_rep");
      check_value("req_hold_794",   {31'h0, cap_req[794]}, 32'h1);
      check_value("req_drop_795",   {31'h0, cap_req[795]}, 32'h0);
      check_value("miss_count_303", count_miss(), 32'd0);

      // Line 304: geometry from the late acceptance.
      run_line(304, 800, NEVER, NEVER);
      check_nominal("late", KERB_A, MARK);

      // Line 479: last visible line makes no request.
      run_line(479, 800, 641, 799);
      check_value("no_req_479",  count_req(), 32'd0);
      check_value("no_miss_479", count_miss(), 32'd0);

      // Reset at x=400 of a road line.
      run_line(304, 400, NEVER, NEVER);
      check_value("pre_rst_road", {20'h0, cap_rgb[399]}, {20'h0, ROAD});
      reset_n = 1'b0;
      #1;
      check_value("midline_rst_rgb", {20'h0, red, green, blue}, 32'h0);
      check_value("midline_rst_req", {31'h0, desc_req}, 32'h0);
      @(posedge pixel_clk);
      @(posedge pixel_clk);
      #1;
      reset_n = 1'b1;
      run_line(304, 800, NEVER, NEVER);
      check_span("grass_after_midline_rst", 0, 639, GRASS);

      // Reset while a request is outstanding.
      run_line(305, 700, NEVER, NEVER);
      check_value("pre_rst_req", {31'h0, cap_req[699]}, 32'h1);
      reset_n = 1'b0;
      #1;
      check_value("req_rst_req",  {31'h0, desc_req}, 32'h0);
      check_value("req_rst_line", {22'h0, desc_line}, 32'h0);
      @(posedge pixel_clk);
      #1;
      reset_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
